// File: rtl/ahb_mtx_pkg.sv
// Shared bus-matrix definitions: HTRANS / HRESP encodings and the
// default-slave state encoding used by the matrix decoder.
package ahb_mtx_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   // Default slave: idle (zero-wait OKAY), first error cycle (wait),
   // second error cycle (ready).
   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

endpackage

// File: rtl/ahb_mtx_dec_param_if.sv
// Input-stage side of the matrix decoder: address-phase request from the
// input port and the multiplexed data-phase response returned to it.
interface ahb_mtx_dec_param_if;
   import ahb_mtx_pkg::*;

   logic        HREADYS;
   logic        sel_dec;
   logic [21:0] decode_addr_dec;
   logic [1:0]  trans_dec;
   logic        active_dec;
   logic        HREADYOUTS;
   logic [1:0]  HRESPS;
   logic [31:0] HRDATAS;
   logic [31:0] HRUSERS;

   // Decoder side
   modport slave (
      input  HREADYS, sel_dec, decode_addr_dec, trans_dec,
      output active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
   );

   // Input-stage side
   modport master (
      output HREADYS, sel_dec, decode_addr_dec, trans_dec,
      input  active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
   );

endinterface

// File: rtl/ahb_mtx_dflt_slv.sv
// Default slave for unmapped addresses: two-cycle ERROR response for
// NONSEQ/SEQ transfers, zero-wait OKAY otherwise, plus a saturating count
// of the erroring transfers it has accepted.
module ahb_mtx_dflt_slv
   import ahb_mtx_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HREADYS,
   input  logic        dflt_sel,
   input  logic        trans_act,     // HTRANS[1]: NONSEQ or SEQ
   output logic        dflt_readyout,
   output logic [1:0]  dflt_resp,
   output logic [15:0] unmapped_cnt
);

   ds_state_t   state_reg, state_next;
   logic [15:0] cnt_reg;
   logic        err_accept;

   assign err_accept = dflt_sel & HREADYS & trans_act;

   // State register; reset abandons any error in progress
   always_ff @(posedge HCLK) begin
      if (!HRESETn) state_reg <= DS_IDLE;
      else          state_reg <= state_next;
   end

   // Next state and response outputs
   always_comb begin
      state_next    = state_reg;
      dflt_readyout = 1'b1;
      dflt_resp     = HRESP_OKAY;
      case (state_reg)
         DS_IDLE: begin
            if (err_accept) state_next = DS_ERR1;
         end
         DS_ERR1: begin
            dflt_readyout = 1'b0;
            dflt_resp     = HRESP_ERROR;
            state_next    = DS_ERR2;
         end
         DS_ERR2: begin
            dflt_resp = HRESP_ERROR;
            // A stalled input stage keeps the ready cycle pending
            if (HREADYS) state_next = err_accept ? DS_ERR1 : DS_IDLE;
         end
         default: state_next = DS_IDLE;
      endcase
   end

   // Count every entry into the first error cycle, saturating at all-ones
   always_ff @(posedge HCLK) begin
      if (!HRESETn)
         cnt_reg <= 16'd0;
      else if ((state_next == DS_ERR1) && (cnt_reg != 16'hFFFF))
         cnt_reg <= cnt_reg + 16'd1;
   end

   assign unmapped_cnt = cnt_reg;

endmodule

// File: rtl/ahb_mtx_dec_param.sv
// Bus-matrix input-stage decoder: routes each address phase to one of
// NUM_PORTS output stages (or the default slave), remembers the route for
// the data phase and returns that port's response.
// Optional feature macro: AHB_MTX_DEC_RUSER_EN builds the HRUSERS mux;
// without it HRUSERS is tied low.
module ahb_mtx_dec_param
   import ahb_mtx_pkg::*;
#(
   parameter int                        NUM_PORTS  = 3,
   parameter logic [22*NUM_PORTS-1:0]   ADDR_BASE  = '0,
   parameter logic [22*NUM_PORTS-1:0]   ADDR_LIMIT = '0
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   ahb_mtx_dec_param_if.slave        bus,
   input  logic [NUM_PORTS-1:0]      active_decs,
   input  logic [NUM_PORTS-1:0]      readyout_decs,
   input  logic [2*NUM_PORTS-1:0]    resp_decs,
   input  logic [32*NUM_PORTS-1:0]   rdata_decs,
   input  logic [32*NUM_PORTS-1:0]   ruser_decs,
   output logic [NUM_PORTS-1:0]      sel_decs,
   output logic [15:0]               unmapped_cnt
);

   localparam int              PW       = $clog2(NUM_PORTS + 1);
   localparam logic [PW-1:0]   DFLT_IDX = PW'(NUM_PORTS);

   logic [NUM_PORTS-1:0] hit;
   logic [PW-1:0]        addr_port;
   logic [PW-1:0]        data_port;
   logic                 dflt_sel;
   logic                 dflt_readyout;
   logic [1:0]           dflt_resp;
   logic                 active_mux;
   logic                 ready_mux;
   logic [1:0]           resp_mux;
   logic [31:0]          rdata_mux;

   generate
      if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_num
         $error("ahb_mtx_dec_param: NUM_PORTS must be in 1..8");
      end
   endgenerate

   // Per-port region match; compares are done as borrow checks so a
   // region touching 0 or the top of the space needs no special case.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_hit
         logic [22:0] ge_diff;
         logic [22:0] le_diff;
         if (ADDR_BASE[22*gi +: 22] > ADDR_LIMIT[22*gi +: 22]) begin : g_bad_range
            $error("ahb_mtx_dec_param: ADDR_BASE exceeds ADDR_LIMIT");
         end
         assign ge_diff = {1'b0, bus.decode_addr_dec} - {1'b0, ADDR_BASE[22*gi +: 22]};
         assign le_diff = {1'b0, ADDR_LIMIT[22*gi +: 22]} - {1'b0, bus.decode_addr_dec};
         assign hit[gi] = ~ge_diff[22] & ~le_diff[22];
      end
   endgenerate

   // Address-phase route: lowest hitting port, else hold the data-phase
   // port through IDLE cycles, else the default slave
   always_comb begin
      addr_port = DFLT_IDX;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (hit[i]) addr_port = PW'(i);
      end
      if ((hit == '0) && (bus.trans_dec == HTRANS_IDLE) && (data_port < DFLT_IDX))
         addr_port = data_port;
   end

   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_sel
         assign sel_decs[gi] = bus.sel_dec & (addr_port == PW'(gi));
      end
   endgenerate

   assign dflt_sel = bus.sel_dec & (addr_port == DFLT_IDX);

   // Address-phase active of the routed stage; default slave is always active
   always_comb begin
      active_mux = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (addr_port == PW'(i)) active_mux = active_decs[i];
      end
   end

   assign bus.active_dec = active_mux;

   // Data-phase route follows the address phase whenever the stage completes
   always_ff @(posedge HCLK) begin
      if (!HRESETn)     data_port <= '0;
      else if (bus.HREADYS) data_port <= addr_port;
   end

   // Data-phase response mux; default slave supplies ready/resp and zero data
   always_comb begin
      ready_mux = dflt_readyout;
      resp_mux  = dflt_resp;
      rdata_mux = 32'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (data_port == PW'(i)) begin
            ready_mux = readyout_decs[i];
            resp_mux  = resp_decs[2*i +: 2];
            rdata_mux = rdata_decs[32*i +: 32];
         end
      end
   end

   assign bus.HREADYOUTS = ready_mux;
   assign bus.HRESPS     = resp_mux;
   assign bus.HRDATAS    = rdata_mux;

`ifdef AHB_MTX_DEC_RUSER_EN
   logic [31:0] ruser_mux;

   // User data follows the same data-phase route as read data
   always_comb begin
      ruser_mux = 32'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (data_port == PW'(i)) ruser_mux = ruser_decs[32*i +: 32];
      end
   end

   assign bus.HRUSERS = ruser_mux;
`else
   logic ruser_unused;
   assign ruser_unused = ^ruser_decs;
   assign bus.HRUSERS  = 32'd0;
`endif

   ahb_mtx_dflt_slv u_dflt (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .HREADYS       (bus.HREADYS),
      .dflt_sel      (dflt_sel),
      .trans_act     (bus.trans_dec[1]),
      .dflt_readyout (dflt_readyout),
      .dflt_resp     (dflt_resp),
      .unmapped_cnt  (unmapped_cnt)
   );

endmodule
